// File: rtl/instr_fetch_buffer.sv
// Instruction-fetch front end: prefetches sequential words into a small FIFO and
// returns one registered instruction per core PC. Define FETCH_PERF_EN for event counters.
module instr_fetch_buffer #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] i_pc,
   output logic [31:0] o_instr,
   output logic        o_ifValid,
   output logic        o_memReqValid,
   input  logic        i_memReqReady,
   output logic [31:0] o_memReqAddr,
   input  logic        i_memRspValid,
   input  logic [31:0] i_memRspData
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] o_redirectCnt,
   output logic [31:0] o_starveCnt
`endif
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);
   localparam logic [PTR_W-1:0] P_ONE = PTR_W'(1);
   localparam logic [CNT_W:0]   CAP   = (CNT_W+1)'(DEPTH);
   localparam logic [31:0]      NO_PC = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {C_HOLD, C_DELIVER, C_WAIT, C_REDIRECT} cls_e;

   logic [DEPTH-1:0][31:0] fifo_q;
   logic [PTR_W-1:0]       rd_ptr, wr_ptr;
   logic [CNT_W-1:0]       fifo_cnt, outstanding, drop_cnt;
   logic [31:0]            fetch_pc, exp_pc, last_pc, pend_tgt;
   logic                   pend_redir;

   cls_e             cls;
   logic [31:0]      pc_a, fetch_nxt, tgt_nxt;
   logic             redirect, deliver, hs, req_stall, push, pend_nxt;
   logic [CNT_W-1:0] out_nxt, cnt_nxt, drop_eff, drop_nxt;
   logic [CNT_W:0]   sum_nxt;

   assign pc_a = i_pc & 32'hFFFF_FFFC;

   always_comb begin
      cls = C_REDIRECT;
      if (pc_a == last_pc)
         cls = C_HOLD;
      else if (pc_a == exp_pc)
         cls = (fifo_cnt != '0) ? C_DELIVER : C_WAIT;
   end

   assign redirect  = (cls == C_REDIRECT);
   assign deliver   = (cls == C_DELIVER);
   assign hs        = o_memReqValid & i_memReqReady;
   assign req_stall = o_memReqValid & ~i_memReqReady;

   // A request accepted after a jump while it was stuck carries the old address,
   // so it joins the discard count the moment it is accepted.
   assign drop_eff = drop_cnt + ((hs && pend_redir) ? C_ONE : '0);
   assign push     = i_memRspValid & ~redirect & (drop_eff == '0);
   assign out_nxt  = outstanding + (hs ? C_ONE : '0) - (i_memRspValid ? C_ONE : '0);
   assign cnt_nxt  = redirect ? '0
                   : fifo_cnt + (push ? C_ONE : '0) - (deliver ? C_ONE : '0);
   assign sum_nxt  = {1'b0, cnt_nxt} + {1'b0, out_nxt};

   // After a jump every word still in flight is stale, including ones already
   // marked for discard, so the drop count becomes the whole in-flight count.
   assign drop_nxt = redirect ? out_nxt
                   : drop_eff - ((i_memRspValid && drop_eff != '0) ? C_ONE : '0);

   always_comb begin
      fetch_nxt = fetch_pc;
      pend_nxt  = pend_redir;
      tgt_nxt   = pend_tgt;
      if (hs) begin
         fetch_nxt = pend_redir ? pend_tgt : fetch_pc + 32'd4;
         pend_nxt  = 1'b0;
      end
      if (redirect) begin
         if (req_stall) begin
            pend_nxt = 1'b1;
            tgt_nxt  = pc_a;
         end else begin
            fetch_nxt = pc_a;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc      <= RESET_PC;
         pend_redir    <= 1'b0;
         pend_tgt      <= RESET_PC;
         outstanding   <= '0;
         drop_cnt      <= '0;
         o_memReqValid <= 1'b0;
         o_memReqAddr  <= RESET_PC;
      end else begin
         fetch_pc    <= fetch_nxt;
         pend_redir  <= pend_nxt;
         pend_tgt    <= tgt_nxt;
         outstanding <= out_nxt;
         drop_cnt    <= drop_nxt;
         if (!req_stall) begin
            o_memReqValid <= (sum_nxt < CAP);
            o_memReqAddr  <= fetch_nxt;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         fifo_cnt <= cnt_nxt;
         if (redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
         end else begin
            if (push)    wr_ptr <= wr_ptr + P_ONE;
            if (deliver) rd_ptr <= rd_ptr + P_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_q[wr_ptr] <= i_memRspData;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_instr   <= '0;
         o_ifValid <= 1'b0;
         last_pc   <= NO_PC;
         exp_pc    <= RESET_PC;
      end else begin
         case (cls)
            C_DELIVER: begin
               o_instr   <= fifo_q[rd_ptr];
               o_ifValid <= 1'b1;
               last_pc   <= pc_a;
               exp_pc    <= exp_pc + 32'd4;
            end
            C_WAIT: o_ifValid <= 1'b0;
            C_REDIRECT: begin
               o_ifValid <= 1'b0;
               last_pc   <= NO_PC;
               exp_pc    <= pc_a;
            end
            default: ;
         endcase
      end
   end

`ifdef FETCH_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_redirectCnt <= '0;
         o_starveCnt   <= '0;
      end else begin
         if (redirect)       o_redirectCnt <= o_redirectCnt + 32'd1;
         if (cls == C_WAIT)  o_starveCnt   <= o_starveCnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Bench for instr_fetch_buffer: queue-based reference model plus a latency-configurable memory.
module tb_instr_fetch_buffer;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] i_pc, o_instr, o_memReqAddr, i_memRspData;
   logic        o_ifValid, o_memReqValid, i_memReqReady, i_memRspValid;
`ifdef FETCH_PERF_EN
   logic [31:0] o_redirectCnt, o_starveCnt;
`endif

   always #5 clk = ~clk;

   instr_fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst(rst), .i_pc(i_pc),
      .o_instr(o_instr), .o_ifValid(o_ifValid),
      .o_memReqValid(o_memReqValid), .i_memReqReady(i_memReqReady),
      .o_memReqAddr(o_memReqAddr),
      .i_memRspValid(i_memRspValid), .i_memRspData(i_memRspData)
`ifdef FETCH_PERF_EN
      , .o_redirectCnt(o_redirectCnt), .o_starveCnt(o_starveCnt)
`endif
   );

   int total = 0;
   int bad   = 0;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return {16'hC0DE, a[17:2]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, want);
      end
   endtask

   // reference model: FIFO as a queue of words, in-flight requests as stale flags
   logic [31:0] m_fetch, m_exp, m_last, m_instr, m_ra, m_tgt;
   bit          m_ifv, m_rv, m_pend, m_deliver;
   logic [31:0] q[$];
   bit          fl[$];
   int unsigned m_redir, m_starve;

   typedef struct { logic [31:0] addr; int due; } mreq_t;
   mreq_t       mq[$];

   int          cyc = 0;
   int          lat;
   bit          rdy, stream, prev_stall;
   logic [31:0] pc, prev_addr;

   task automatic model_reset();
      m_fetch = RESET_PC; m_exp = RESET_PC; m_last = 32'hFFFF_FFFF;
      m_instr = '0; m_ra = RESET_PC; m_tgt = '0;
      m_ifv = 0; m_rv = 0; m_pend = 0; m_deliver = 0;
      q.delete(); fl.delete(); mq.delete();
      m_redir = 0; m_starve = 0; prev_stall = 0;
   endtask

   task automatic compare();
      chk("ifValid", 32'(o_ifValid), 32'(m_ifv));
      chk("instr", o_instr, m_instr);
      if (o_ifValid) chk("nostale", o_instr, memf(m_last));
      chk("reqValid", 32'(o_memReqValid), 32'(m_rv));
      if (m_rv) chk("reqAddr", o_memReqAddr, m_ra);
      if (prev_stall) begin
         chk("reqHoldV", 32'(o_memReqValid), 32'd1);
         chk("reqHoldA", o_memReqAddr, prev_addr);
      end
`ifdef FETCH_PERF_EN
      chk("redirectCnt", o_redirectCnt, m_redir);
      chk("starveCnt", o_starveCnt, m_starve);
`endif
   endtask

   // Drive one cycle at a negedge, advance the model over the coming posedge, check at next negedge.
   task automatic step();
      logic [31:0] pa, rd;
      bit          hs, rv, st;
      int          cls;
      i_pc = pc;
      i_memReqReady = rdy;
      if (o_memReqValid && rdy) mq.push_back('{o_memReqAddr, cyc + lat});
      rv = 0; rd = '0;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
         rv = 1; rd = memf(mq[0].addr);
         mq.delete(0);
      end
      i_memRspValid = rv;
      i_memRspData  = rd;
      prev_stall = o_memReqValid && !rdy;
      prev_addr  = o_memReqAddr;

      pa = pc & 32'hFFFF_FFFC;
      hs = m_rv && rdy;
      m_deliver = 0;
      if (pa == m_last)                   cls = 0;
      else if (pa == m_exp && q.size() > 0) cls = 1;
      else if (pa == m_exp)               cls = 2;
      else                                cls = 3;
      if (cls == 1) begin
         m_instr = q.pop_front(); m_ifv = 1; m_last = pa; m_exp = pa + 32'd4; m_deliver = 1;
      end
      if (cls == 2) begin m_ifv = 0; m_starve++; end
      if (hs) begin
         fl.push_back(m_pend || cls == 3);
         m_fetch = m_pend ? m_tgt : m_fetch + 32'd4;
         m_pend = 0;
      end
      if (rv && fl.size() > 0) begin
         st = fl.pop_front();
         if (!st && cls != 3) q.push_back(rd);
      end
      if (cls == 3) begin
         q.delete();
         foreach (fl[i]) fl[i] = 1;
         m_exp = pa; m_last = 32'hFFFF_FFFF; m_ifv = 0; m_redir++;
         if (m_rv && !rdy) begin m_pend = 1; m_tgt = pa; end
         else m_fetch = pa;
      end
      if (!(m_rv && !rdy)) begin
         m_rv = (q.size() + fl.size() < DEPTH);
         m_ra = m_fetch;
      end

      cyc++;
      if (stream && m_deliver) pc = pc + 32'd4;
      @(negedge clk);
      compare();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; i_pc = RESET_PC; i_memReqReady = 1'b0;
      i_memRspValid = 1'b0; i_memRspData = '0;
      pc = RESET_PC; rdy = 1; lat = 0; stream = 1;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ifValid", 32'(o_ifValid), 32'd0);
      chk("rst_instr", o_instr, 32'd0);
      chk("rst_reqValid", 32'(o_memReqValid), 32'd0);
      chk("rst_reqAddr", o_memReqAddr, 32'h0000_0000);
      rst = 1'b0;

      // sequential run, zero-latency memory
      for (int k = 0; k < 40 && m_last != 32'h8; k++) step();
      chk("seq_v", 32'(o_ifValid), 32'd1);
      chk("seq_instr8", o_instr, 32'hC0DE_0002);

      // hold at 8
      stream = 0; pc = 32'h8;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("hold_v", 32'(o_ifValid), 32'd1);
         chk("hold_instr", o_instr, 32'hC0DE_0002);
      end
      stream = 1; pc = 32'hC;
      step();
      chk("after_hold", o_instr, 32'hC0DE_0003);

      // redirect with requests in flight, latency 3
      lat = 3;
      for (int k = 0; k < 40 && m_last != 32'h10; k++) step();
      chk("pre_jump", o_instr, 32'hC0DE_0004);
      pc = 32'h100;
      step();
      chk("jump_v", 32'(o_ifValid), 32'd0);
      for (int k = 0; k < 40 && o_ifValid !== 1'b1; k++) step();
      chk("redir_wait", 32'(o_ifValid), 32'd1);
      chk("redir_first", o_instr, 32'hC0DE_0040);

      // backpressure
      repeat (3) step();
      rdy = 0;
      repeat (6) step();
      chk("bp_starve", 32'(o_ifValid), 32'd0);
      chk("bp_reqv", 32'(o_memReqValid), 32'd1);
      rdy = 1;
      repeat (8) step();

      // async reset mid-stream
      lat = 1;
      repeat (6) step();
      #2 rst = 1'b1;
      #1;
      chk("arst_ifValid", 32'(o_ifValid), 32'd0);
      chk("arst_reqValid", 32'(o_memReqValid), 32'd0);
      chk("arst_instr", o_instr, 32'd0);
      model_reset();
      i_memRspValid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // restart at RESET_PC, then redirect while a request at 0x20 is stuck
      lat = 2; stream = 0;
      pc = RESET_PC; rdy = 0; step();
      chk("restart_v", 32'(o_memReqValid), 32'd1);
      chk("restart_addr", o_memReqAddr, 32'h0000_0000);
      pc = 32'h20; rdy = 1; step();
      pc = 32'h20; rdy = 0; step();
      chk("pend_addr", o_memReqAddr, 32'h0000_0020);
      pc = 32'h200; rdy = 0; step();
      chk("pend_hold", o_memReqAddr, 32'h0000_0020);
      pc = 32'h200; rdy = 1; step();
      chk("redir_reqv", 32'(o_memReqValid), 32'd1);
      chk("redir_addr", o_memReqAddr, 32'h0000_0200);
      stream = 1;
      for (int k = 0; k < 40 && o_ifValid !== 1'b1; k++) step();
      chk("pend_first", o_instr, 32'hC0DE_0080);
      repeat (4) step();

      // address wrap, low PC bits ignored
      lat = 1; pc = 32'hFFFF_FFF9;
      for (int k = 0; k < 40 && m_last != 32'h0; k++) step();
      chk("wrap_instr0", o_instr, 32'hC0DE_0000);
      step();
      chk("wrap_instr4", o_instr, 32'hC0DE_0001);
      repeat (4) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
